systolic_result_drain: RTL and testbench

//   Read-side counterpart of the systolic multiply array. On a start pulse it snapshots
//   the M x N accumulator matrix and streams it out one row per beat over a valid/ready

---
 rtl/systolic_pkg.sv | 12 +
 rtl/systolic_result_drain_narrow.sv | 42 ++++
 rtl/systolic_result_drain.sv | 117 +++++++++++
 tb/tb_systolic_result_drain.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared state type and default widths for the systolic result drain
package systolic_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } drain_state_e;

  localparam int ACC_W_DEF = 16;
  localparam int OUT_W_DEF = 8;

endpackage

// File: rtl/systolic_result_drain_narrow.sv
// rtl/systolic_result_drain_narrow.sv - drain_narrow: signed ACC_WIDTH -> OUT_WIDTH element narrowing
// DRAIN_SAT_EN defined: clamp to the OUT_WIDTH signed range and flag clipping; undefined: wrap.
module drain_narrow
  import systolic_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_W_DEF,
  parameter int OUT_WIDTH = OUT_W_DEF
) (
  input  logic signed [ACC_WIDTH-1:0] acc_in,
  output logic signed [OUT_WIDTH-1:0] out_elem,
  output logic                        clip
);

  generate
    if (OUT_WIDTH == ACC_WIDTH) begin : g_pass
      assign out_elem = acc_in;
      assign clip     = 1'b0;
    end else begin : g_narrow
`ifdef DRAIN_SAT_EN
      localparam logic signed [ACC_WIDTH-1:0] MAX_V =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
      localparam logic signed [ACC_WIDTH-1:0] MIN_V = ~MAX_V;

      always_comb begin
        out_elem = acc_in[OUT_WIDTH-1:0];
        clip     = 1'b0;
        if (acc_in > MAX_V) begin
          out_elem = MAX_V[OUT_WIDTH-1:0];
          clip     = 1'b1;
        end else if (acc_in < MIN_V) begin
          out_elem = MIN_V[OUT_WIDTH-1:0];
          clip     = 1'b1;
        end
      end
`else
      assign out_elem = OUT_WIDTH'(acc_in);
      assign clip     = 1'b0;
`endif
    end
  endgenerate

endmodule

// File: rtl/systolic_result_drain.sv
// rtl/systolic_result_drain.sv - snapshots the M x N accumulator matrix and streams it one row per beat
// Narrowing behaviour selected by DRAIN_SAT_EN inside drain_narrow.
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter int M         = 4,
  parameter int N         = 4,
  parameter int ACC_WIDTH = ACC_W_DEF,
  parameter int OUT_WIDTH = OUT_W_DEF,
  localparam int ROW_W    = (M > 1) ? $clog2(M) : 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [M*N*ACC_WIDTH-1:0]   p_flat,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N*OUT_WIDTH-1:0]     out_data,
  output logic [ROW_W-1:0]           out_row,
  output logic                       out_last,
  output logic                       done,
  output logic                       sat_any
);

  localparam int ROW_BITS = N * ACC_WIDTH;
  localparam int MAT_BITS = M * ROW_BITS;

  drain_state_e         state_q, state_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [MAT_BITS-1:0]  snap_q, snap_d;
  logic                 done_q, done_d;
  logic                 sat_q, sat_d;

  logic [ROW_BITS-1:0]  row_data;
  logic [N-1:0]         clip;
  logic                 last;
  logic                 hs;

  assign row_data = snap_q[int'(row_q)*ROW_BITS +: ROW_BITS];
  assign last     = (row_q == ROW_W'(M-1));

  generate
    for (genvar j = 0; j < N; j++) begin : g_col
      drain_narrow #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
      ) u_narrow (
        .acc_in   (row_data[j*ACC_WIDTH +: ACC_WIDTH]),
        .out_elem (out_data[j*OUT_WIDTH +: OUT_WIDTH]),
        .clip     (clip[j])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      snap_q  <= '0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      snap_q  <= snap_d;
      done_q  <= done_d;
      sat_q   <= sat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    snap_d    = snap_q;
    done_d    = 1'b0;
    sat_d     = sat_q;
    busy      = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    hs        = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Capture frees the array immediately; stream runs from the private copy.
        if (start) begin
          state_d = STREAM;
          row_d   = '0;
          snap_d  = p_flat;
          sat_d   = 1'b0;
        end
      end
      STREAM: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = last;
        hs        = out_ready;
        if (hs) begin
          if (|clip) sat_d = 1'b1;
          if (last) begin
            state_d = IDLE;
            row_d   = '0;
            done_d  = 1'b1;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_row = row_q;
  assign done    = done_q;
  assign sat_any = sat_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// tb/tb_systolic_result_drain.sv - directed vector bench for systolic_result_drain (both DRAIN_SAT_EN builds)
module tb_systolic_result_drain;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [255:0] p_flat;
  logic         busy;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_row;
  logic         out_last;
  logic         done;
  logic         sat_any;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  systolic_result_drain dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .p_flat    (p_flat),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_last  (out_last),
    .done      (done),
    .sat_any   (sat_any)
  );

  typedef struct {
    logic        start;
    logic        ready;
    logic [7:0]  base;
    logic        ev;
    logic [1:0]  erow;
    logic        elast;
    logic        edone;
    logic [31:0] edata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic set_mat(input logic [7:0] base);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        p_flat[(i*4+j)*16 +: 16] = 16'(base) + 16'(i*4+j);
  endtask

  task automatic add(input logic s, input logic r, input logic [7:0] b, input logic v,
                     input logic [1:0] row, input logic l, input logic d, input logic [31:0] data);
    vec_t t;
    t.start = s; t.ready = r; t.base = b; t.ev = v;
    t.erow = row; t.elast = l; t.edone = d; t.edata = data;
    vecs.push_back(t);
  endtask

  logic [31:0] exp0, exp1;
  logic        exp_sat;

  initial begin
    // Test 1: full-rate stream of p[i][j]=i*4+j
    add(1,1,8'h00, 0,0,0,0, 32'h0);
    add(0,1,8'h00, 1,0,0,0, 32'h03020100);
    add(0,1,8'h00, 1,1,0,0, 32'h07060504);
    add(0,1,8'h00, 1,2,0,0, 32'h0B0A0908);
    add(0,1,8'h00, 1,3,1,0, 32'h0F0E0D0C);
    add(0,1,8'h00, 0,0,0,1, 32'h0);
    add(0,1,8'h00, 0,0,0,0, 32'h0);
    // Test 2: out_ready toggling, each row held until accepted
    add(1,0,8'h00, 0,0,0,0, 32'h0);
    add(0,0,8'h00, 1,0,0,0, 32'h03020100);
    add(0,1,8'h00, 1,0,0,0, 32'h03020100);
    add(0,0,8'h00, 1,1,0,0, 32'h07060504);
    add(0,1,8'h00, 1,1,0,0, 32'h07060504);
    add(0,0,8'h00, 1,2,0,0, 32'h0B0A0908);
    add(0,1,8'h00, 1,2,0,0, 32'h0B0A0908);
    add(0,0,8'h00, 1,3,1,0, 32'h0F0E0D0C);
    add(0,1,8'h00, 1,3,1,0, 32'h0F0E0D0C);
    add(0,1,8'h00, 0,0,0,1, 32'h0);
    // Test 3: start mid-stream and p_flat change ignored
    add(1,1,8'h00, 0,0,0,0, 32'h0);
    add(0,1,8'h00, 1,0,0,0, 32'h03020100);
    add(1,1,8'h40, 1,1,0,0, 32'h07060504);
    add(0,1,8'h40, 1,2,0,0, 32'h0B0A0908);
    add(0,1,8'h40, 1,3,1,0, 32'h0F0E0D0C);
    // Test 4: start in the done cycle with a new matrix
    add(1,1,8'h20, 0,0,0,1, 32'h0);
    add(0,1,8'h20, 1,0,0,0, 32'h23222120);
    add(0,1,8'h20, 1,1,0,0, 32'h27262524);
    add(0,1,8'h20, 1,2,0,0, 32'h2B2A2928);
    add(0,1,8'h20, 1,3,1,0, 32'h2F2E2D2C);
    add(0,1,8'h20, 0,0,0,1, 32'h0);

    reset_n   = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    set_mat(8'h00);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_row",   64'(out_row),   64'd0);
    chk("rst_last",  64'(out_last),  64'd0);
    chk("rst_done",  64'(done),      64'd0);
    chk("rst_sat",   64'(sat_any),   64'd0);
    @(negedge clk);

    foreach (vecs[k]) begin
      start     = vecs[k].start;
      out_ready = vecs[k].ready;
      set_mat(vecs[k].base);
      #1;
      chk($sformatf("v%0d_valid", k), 64'(out_valid), 64'(vecs[k].ev));
      chk($sformatf("v%0d_busy", k),  64'(busy),      64'(vecs[k].ev));
      chk($sformatf("v%0d_row", k),   64'(out_row),   64'(vecs[k].erow));
      chk($sformatf("v%0d_last", k),  64'(out_last),  64'(vecs[k].elast));
      chk($sformatf("v%0d_done", k),  64'(done),      64'(vecs[k].edone));
      if (vecs[k].ev)
        chk($sformatf("v%0d_data", k), 64'(out_data), 64'(vecs[k].edata));
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);

    // Test 5: out-of-range elements
`ifdef DRAIN_SAT_EN
    exp0 = 32'h0302017F; exp1 = 32'h07068004; exp_sat = 1'b1;
`else
    exp0 = 32'h0302012C; exp1 = 32'h07063804; exp_sat = 1'b0;
`endif
    set_mat(8'h00);
    p_flat[0 +: 16]          = 16'd300;
    p_flat[(1*4+1)*16 +: 16] = 16'hFF38;
    start     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("sat_row0_data", 64'(out_data), 64'(exp0));
    chk("sat_before_hs", 64'(sat_any),  64'd0);
    @(negedge clk);
    #1;
    chk("sat_row1_data", 64'(out_data), 64'(exp1));
    chk("sat_after_row0", 64'(sat_any), 64'(exp_sat));
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("sat_done",   64'(done),    64'd1);
    chk("sat_sticky", 64'(sat_any), 64'(exp_sat));
    @(negedge clk);
    #1;
    chk("sat_held_idle", 64'(sat_any), 64'(exp_sat));

    // Test 6: reset mid-stream
    set_mat(8'h00);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("r6_valid_pre", 64'(out_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("r6_valid_async", 64'(out_valid), 64'd0);
    chk("r6_busy_async",  64'(busy),      64'd0);
    chk("r6_sat_cleared", 64'(sat_any),   64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("r6_no_done_a", 64'(done),      64'd0);
    chk("r6_valid_low", 64'(out_valid), 64'd0);
    @(negedge clk);
    #1;
    chk("r6_no_done_b", 64'(done), 64'd0);
    set_mat(8'h50);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("r6_restart_valid", 64'(out_valid), 64'd1);
    chk("r6_restart_row",   64'(out_row),   64'd0);
    chk("r6_restart_data",  64'(out_data),  64'h53525150);
    @(negedge clk);
    #1;
    chk("r6_row1",      64'(out_row),  64'd1);
    chk("r6_row1_data", 64'(out_data), 64'h57565554);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
